// File: rtl/data_memory_sync.sv
// Parametrised single-port data memory with post-reset zero-fill, configurable
// read latency, read-during-write policy and out-of-range address detection.
module data_memory_sync #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int DEPTH          = 256,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_NEW        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] MemOut,
  output logic                  ReadValid,
  output logic                  Ready,
  output logic                  AddrError,
  output logic                  o_dbg_state
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t                LP_RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
  localparam logic [ADDR_WIDTH:0]   LP_DEPTH     = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST      = ADDR_WIDTH'(DEPTH - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_clr_cnt;
  logic                    r_ready;
  logic                    w_clearing;

  // Handshake: a request is accepted when MemRead/MemWrite is high at a rising
  // edge while Ready is high; ReadValid qualifies MemOut for exactly one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= LP_RST_STATE;
      r_ready   <= 1'b0;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_READY);
      if (w_clearing) r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_cnt == LP_LAST) w_state_nxt = ST_READY;
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = LP_RST_STATE;
    endcase
  end

  always_comb begin
    w_clearing  = (r_state == ST_CLEAR);
    o_dbg_state = r_state;
  end

  assign Ready = r_ready;

  logic                  w_in_range;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_waddr;
  logic [ADDR_WIDTH-1:0] w_ram_raddr;
  logic [DATA_WIDTH-1:0] w_ram_wdata;

  assign w_in_range  = ({1'b0, Address} < LP_DEPTH);
  assign w_rd_acc    = r_ready & MemRead;
  assign w_wr_acc    = r_ready & MemWrite;
  // The clear sweep and user traffic share the single write port; they never overlap.
  assign w_ram_we    = w_clearing | (w_wr_acc & w_in_range);
  assign w_ram_waddr = w_clearing ? r_clr_cnt : Address;
  assign w_ram_wdata = w_clearing ? '0 : WriteData;
  assign w_ram_raddr = w_in_range ? Address : '0;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_ram_q;

  always_ff @(posedge clock) begin
    if (w_ram_we) r_mem[w_ram_waddr] <= w_ram_wdata;
    if (w_rd_acc) r_ram_q <= r_mem[w_ram_raddr];
  end

  logic                  r_vld1;
  logic                  r_zero1;
  logic                  r_rdw_hit;
  logic [DATA_WIDTH-1:0] r_rdw_data;
  logic                  r_addr_err;
  logic [DATA_WIDTH-1:0] w_rd_data1;

  // r_zero1 resets high so the un-reset RAM output register never reaches MemOut.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld1     <= 1'b0;
      r_zero1    <= 1'b1;
      r_rdw_hit  <= 1'b0;
      r_rdw_data <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_vld1     <= w_rd_acc;
      r_addr_err <= (w_rd_acc | w_wr_acc) & ~w_in_range;
      if (w_rd_acc) begin
        r_zero1    <= ~w_in_range;
        r_rdw_hit  <= (RDW_NEW != 0) & w_wr_acc & w_in_range;
        r_rdw_data <= WriteData;
      end
    end
  end

  assign w_rd_data1 = r_zero1 ? '0 : (r_rdw_hit ? r_rdw_data : r_ram_q);
  assign AddrError  = r_addr_err;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  r_vld2;
    logic [DATA_WIDTH-1:0] r_dout2;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_vld2  <= 1'b0;
        r_dout2 <= '0;
      end else begin
        r_vld2 <= r_vld1;
        if (r_vld1) r_dout2 <= w_rd_data1;
      end
    end

    assign MemOut    = r_dout2;
    assign ReadValid = r_vld2;
  end else begin : g_lat1
    assign MemOut    = w_rd_data1;
    assign ReadValid = r_vld1;
  end

endmodule

// File: tb/tb_data_memory_sync.sv
// Self-checking bench for data_memory_sync: three instances with different
// depth/latency/RDW/clear settings share one stimulus stream and a reference model.
module tb_data_memory_sync;

  logic            clock;
  logic            reset_n;
  logic            mem_write;
  logic            mem_read;
  logic [7:0]      address;
  logic [15:0]     write_data;
  logic [2:0][15:0] mem_out;
  logic [2:0]      read_valid;
  logic [2:0]      ready;
  logic [2:0]      addr_error;
  logic [2:0]      dbg_state;

  int checks;
  int errors;

  // instance configuration (must match the instantiations below)
  int depth_k [3];
  int lat_k   [3];
  bit rdw_k   [3];
  bit clr_k   [3];

  // reference model
  logic [15:0] m_mem     [3][256];
  bit          m_known   [3][256];
  bit          m_ready   [3];
  int          m_clr_left[3];
  bit          pv        [3][2];
  bit          pk        [3][2];
  logic [15:0] pd        [3][2];
  bit          exp_rv    [3];
  bit          exp_ae    [3];
  bit          exp_dk    [3];
  logic [15:0] exp_dout  [3];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  data_memory_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(256), .READ_LATENCY(1),
                     .RDW_NEW(0), .CLEAR_ON_RESET(1)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .MemWrite(mem_write), .MemRead(mem_read),
    .Address(address), .WriteData(write_data), .MemOut(mem_out[0]),
    .ReadValid(read_valid[0]), .Ready(ready[0]), .AddrError(addr_error[0]),
    .o_dbg_state(dbg_state[0]));

  data_memory_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(200), .READ_LATENCY(2),
                     .RDW_NEW(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .MemWrite(mem_write), .MemRead(mem_read),
    .Address(address), .WriteData(write_data), .MemOut(mem_out[1]),
    .ReadValid(read_valid[1]), .Ready(ready[1]), .AddrError(addr_error[1]),
    .o_dbg_state(dbg_state[1]));

  data_memory_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(160), .READ_LATENCY(2),
                     .RDW_NEW(0), .CLEAR_ON_RESET(0)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .MemWrite(mem_write), .MemRead(mem_read),
    .Address(address), .WriteData(write_data), .MemOut(mem_out[2]),
    .ReadValid(read_valid[2]), .Ready(ready[2]), .AddrError(addr_error[2]),
    .o_dbg_state(dbg_state[2]));

  // ---------------- driver tasks (called in the low clock phase) ----------------
  task automatic assert_reset();
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    address    = '0;
    write_data = '0;
    reset_n    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 2; s++) begin
        pv[k][s] = 1'b0;
        pk[k][s] = 1'b1;
        pd[k][s] = '0;
      end
      exp_rv[k]     = 1'b0;
      exp_ae[k]     = 1'b0;
      exp_dk[k]     = 1'b1;
      exp_dout[k]   = '0;
      m_ready[k]    = 1'b0;
      m_clr_left[k] = clr_k[k] ? depth_k[k] : 1;
      // any abort is followed by a full sweep before the next accepted request
      if (clr_k[k]) begin
        for (int a = 0; a < 256; a++) begin
          m_mem[k][a]   = '0;
          m_known[k][a] = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Present one cycle of stimulus, advance the model by one edge, return at negedge.
  task automatic drive(input bit we, input bit re, input logic [7:0] a, input logic [15:0] wd);
    logic [15:0] rd_v;
    bit rd_kn, acc_r, acc_w, inr;
    mem_write  = we;
    mem_read   = re;
    address    = a;
    write_data = wd;
    @(posedge clock);
    for (int k = 0; k < 3; k++) begin
      acc_r = m_ready[k] && re;
      acc_w = m_ready[k] && we;
      inr   = (int'(a) < depth_k[k]);
      if (!inr) begin
        rd_v = '0; rd_kn = 1'b1;
      end else if (acc_w && rdw_k[k]) begin
        rd_v = wd; rd_kn = 1'b1;
      end else begin
        rd_v = m_mem[k][a]; rd_kn = m_known[k][a];
      end
      if (acc_w && inr) begin
        m_mem[k][a]   = wd;
        m_known[k][a] = 1'b1;
      end
      pv[k][0] = pv[k][1]; pd[k][0] = pd[k][1]; pk[k][0] = pk[k][1];
      pv[k][1] = 1'b0;
      if (acc_r) begin
        pv[k][lat_k[k]-1] = 1'b1;
        pd[k][lat_k[k]-1] = rd_v;
        pk[k][lat_k[k]-1] = rd_kn;
      end
      exp_rv[k] = pv[k][0];
      if (pv[k][0]) begin
        exp_dout[k] = pd[k][0];
        exp_dk[k]   = pk[k][0];
      end
      exp_ae[k] = (acc_r || acc_w) && !inr;
      if (!m_ready[k]) begin
        m_clr_left[k]--;
        if (m_clr_left[k] == 0) m_ready[k] = 1'b1;
      end
    end
    @(negedge clock);
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    assert_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (mem_out[k] !== 16'h0 || read_valid[k] !== 1'b0 || addr_error[k] !== 1'b0 || ready[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset k=%0d dout=%h rv=%b ae=%b rdy=%b want 0/0/0/0",
                 k, mem_out[k], read_valid[k], addr_error[k], ready[k]);
      end
    end
  endtask

  task automatic test_clear_sweep();
    int n;
    int first_rdy[3];
    release_reset();
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b0, 8'h00, 16'h0);
    checks++;
    if (ready[0] !== 1'b0 || ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear_ready rdy0=%b rdy1=%b want 0", ready[0], ready[1]);
    end
    assert_reset();
    release_reset();
    for (int k = 0; k < 3; k++) first_rdy[k] = -1;
    n = 0;
    while (n < 400 && ready[0] !== 1'b1) begin
      n++;
      if (n == 10) drive(1'b1, 1'b1, 8'h00, 16'h5555);
      else         drive(1'b0, 1'b0, 8'h00, 16'h0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ready[k] !== m_ready[k] || read_valid[k] !== exp_rv[k] || addr_error[k] !== exp_ae[k]
            || (clr_k[k] && dbg_state[k] !== m_ready[k])) begin
          errors++;
          $display("FAIL sweep k=%0d cyc=%0d rdy=%b/%b rv=%b/%b ae=%b/%b st=%b",
                   k, n, ready[k], m_ready[k], read_valid[k], exp_rv[k], addr_error[k], exp_ae[k], dbg_state[k]);
        end
        if (ready[k] === 1'b1 && first_rdy[k] < 0) first_rdy[k] = n;
      end
    end
    checks++;
    if (first_rdy[0] != 256 || first_rdy[1] != 200 || first_rdy[2] != 1) begin
      errors++;
      $display("FAIL ready_rise got %0d/%0d/%0d want 256/200/1", first_rdy[0], first_rdy[1], first_rdy[2]);
    end
  endtask

  task automatic test_clear_readback();
    int z0;
    z0 = 0;
    for (int a = 0; a < 258; a++) begin
      if (a < 256) drive(1'b0, 1'b1, 8'(a), 16'h0);
      else         drive(1'b0, 1'b0, 8'h00, 16'h0);
      if (read_valid[0] === 1'b1 && mem_out[0] === 16'h0000) z0++;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (read_valid[k] !== exp_rv[k] || addr_error[k] !== exp_ae[k] || ready[k] !== m_ready[k]
            || (exp_dk[k] && mem_out[k] !== exp_dout[k])) begin
          errors++;
          $display("FAIL readback k=%0d a=%0d rv=%b/%b ae=%b/%b rdy=%b/%b dout=%h/%h", k, a,
                   read_valid[k], exp_rv[k], addr_error[k], exp_ae[k], ready[k], m_ready[k], mem_out[k], exp_dout[k]);
        end
      end
    end
    checks++;
    if (z0 != 256) begin
      errors++;
      $display("FAIL cleared_zero_reads got %0d want 256", z0);
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b0, 8'h12, 16'hBEEF);
    for (int s = 1; s <= 2; s++) begin
      if (s == 1) drive(1'b0, 1'b1, 8'h12, 16'h0);
      else        drive(1'b0, 1'b0, 8'h00, 16'h0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (read_valid[k] !== (lat_k[k] == s) || ((lat_k[k] <= s) && mem_out[k] !== 16'hBEEF)) begin
          errors++;
          $display("FAIL write_read k=%0d step=%0d rv=%b dout=%h want rv=%b dout=beef",
                   k, s, read_valid[k], mem_out[k], (lat_k[k] == s));
        end
      end
    end
  endtask

  task automatic test_rdw();
    logic [15:0] want;
    drive(1'b1, 1'b0, 8'h05, 16'h1111);
    for (int s = 1; s <= 4; s++) begin
      case (s)
        1:       drive(1'b1, 1'b1, 8'h05, 16'h2222);
        3:       drive(1'b0, 1'b1, 8'h05, 16'h0);
        default: drive(1'b0, 1'b0, 8'h00, 16'h0);
      endcase
      for (int k = 0; k < 3; k++) begin
        bit on;
        on   = (s <= 2) ? (lat_k[k] == s) : (lat_k[k] == s - 2);
        want = (s <= 2 && !rdw_k[k]) ? 16'h1111 : 16'h2222;
        checks++;
        if (read_valid[k] !== on || (on && mem_out[k] !== want)) begin
          errors++;
          $display("FAIL rdw k=%0d step=%0d rv=%b dout=%h want rv=%b dout=%h", k, s, read_valid[k], mem_out[k], on, want);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(i), 16'h00A0 + 16'(i));
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(1'b0, 1'b1, 8'(c), 16'h0);
      else       drive(1'b0, 1'b0, 8'h00, 16'h0);
      for (int k = 0; k < 3; k++) begin
        int idx;
        bit on;
        idx = c - (lat_k[k] - 1);
        on  = (idx >= 0 && idx < 4);
        checks++;
        if (read_valid[k] !== on || (on && mem_out[k] !== 16'h00A0 + 16'(idx))) begin
          errors++;
          $display("FAIL back_to_back k=%0d cyc=%0d rv=%b dout=%h want rv=%b dout=%h",
                   k, c, read_valid[k], mem_out[k], on, 16'h00A0 + 16'(idx));
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b0, 8'd10, 16'h0A0A);
    drive(1'b1, 1'b0, 8'd210, 16'hFFFF);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (addr_error[k] !== (210 >= depth_k[k])) begin
        errors++;
        $display("FAIL oor_write_err k=%0d ae=%b want %b", k, addr_error[k], (210 >= depth_k[k]));
      end
    end
    for (int s = 1; s <= 2; s++) begin
      if (s == 1) drive(1'b0, 1'b1, 8'd210, 16'h0);
      else        drive(1'b0, 1'b0, 8'h00, 16'h0);
      for (int k = 0; k < 3; k++) begin
        logic [15:0] want;
        want = (210 < depth_k[k]) ? 16'hFFFF : 16'h0000;
        checks++;
        if (addr_error[k] !== ((s == 1) && 210 >= depth_k[k]) || read_valid[k] !== (lat_k[k] == s)
            || (lat_k[k] == s && mem_out[k] !== want)) begin
          errors++;
          $display("FAIL oor_read k=%0d step=%0d ae=%b rv=%b dout=%h want dout=%h", k, s,
                   addr_error[k], read_valid[k], mem_out[k], want);
        end
      end
    end
    for (int s = 1; s <= 2; s++) begin
      if (s == 1) drive(1'b0, 1'b1, 8'd10, 16'h0);
      else        drive(1'b0, 1'b0, 8'h00, 16'h0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (read_valid[k] !== (lat_k[k] == s) || (lat_k[k] == s && mem_out[k] !== 16'h0A0A)) begin
          errors++;
          $display("FAIL no_alias k=%0d step=%0d rv=%b dout=%h want 0a0a", k, s, read_valid[k], mem_out[k]);
        end
      end
    end
    for (int s = 1; s <= 3; s++) begin
      if (s == 1) drive(1'b1, 1'b1, 8'd210, 16'h1234);
      else        drive(1'b0, 1'b0, 8'h00, 16'h0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (addr_error[k] !== ((s == 1) && 210 >= depth_k[k])) begin
          errors++;
          $display("FAIL oor_rw_single_pulse k=%0d step=%0d ae=%b want %b", k, s,
                   addr_error[k], ((s == 1) && 210 >= depth_k[k]));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 402; i++) begin
      if (i < 400) begin
        logic [7:0] a;
        a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
      end else begin
        drive(1'b0, 1'b0, 8'h00, 16'h0);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (read_valid[k] !== exp_rv[k] || addr_error[k] !== exp_ae[k] || ready[k] !== m_ready[k]
            || (exp_dk[k] && mem_out[k] !== exp_dout[k])) begin
          errors++;
          $display("FAIL random k=%0d i=%0d rv=%b/%b ae=%b/%b rdy=%b/%b dout=%h/%h", k, i,
                   read_valid[k], exp_rv[k], addr_error[k], exp_ae[k], ready[k], m_ready[k], mem_out[k], exp_dout[k]);
        end
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    depth_k    = '{256, 200, 160};
    lat_k      = '{1, 2, 2};
    rdw_k      = '{1'b0, 1'b1, 1'b0};
    clr_k      = '{1'b1, 1'b1, 1'b0};
    reset_n    = 1'b1;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    address    = '0;
    write_data = '0;
    #2;
    test_reset();
    test_clear_sweep();
    test_clear_readback();
    test_write_read();
    test_rdw();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
